uart_rx_fifo: RTL and testbench

// Serial receive front-end for the CPU's UART_RX pin: 8N1 receiver plus a

---
 rtl/uart_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a two-flop input synchroniser feeding a show-ahead
// byte FIFO; the CPU pops the head byte with a one-cycle rd_en pulse.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          n_reset,
  input  logic                          uart_rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TICK_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = PTR_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic              rx_meta_q, rx_s_q;
  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              push;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, do_push, do_pop;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        // LSB arrives first, so shift right and insert at the MSB
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop frees the slot in the same edge, so a push into a full FIFO with a pop is not an overrun
  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    do_pop    = rd_en && !empty;
    do_push   = push && (!full || do_pop);
    overrun_d = push && full && !do_pop;
    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rx_meta_q   <= uart_rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign rd_valid  = !empty;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 10 clocks/bit with a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clock   = 1'b0;
  logic       n_reset = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rd_en   = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  int unsigned fe0, ov0;

  uart_rx_fifo #(
    .CLK_HZ    (1000000),
    .BAUD      (100000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .uart_rx  (uart_rx),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; one full 8N1 frame, optional pop aligned with the push edge
  task automatic send(input logic [7:0] data, input logic stop_bit, input logic pop_at_push);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int c = 0; c < 100; c++) begin
      uart_rx = frame[c/10];
      rd_en   = pop_at_push && (c == 97);
      @(negedge clock);
    end
    rd_en   = 1'b0;
    uart_rx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [9:0] frame;

    repeat (3) @(negedge clock);
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    n_reset = 1'b1;
    idle(5);

    // 1: two back-to-back bytes
    send(8'h55, 1'b1, 1'b0);
    send(8'hA3, 1'b1, 1'b0);
    check("t1_count", count, 2);
    check("t1_valid", rd_valid, 1);
    check("t1_head0", rd_data, 8'h55);
    pop();
    check("t1_head1", rd_data, 8'hA3);
    check("t1_count1", count, 1);
    pop();
    check("t1_empty", rd_valid, 0);
    check("t1_count0", count, 0);

    // 2: short low glitch is rejected
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (3) @(negedge clock);
    idle(30);
    check("t2_count", count, 0);
    check("t2_ferr", fe_cnt - fe0, 0);
    send(8'h5A, 1'b1, 1'b0);
    check("t2_after_cnt", count, 1);
    check("t2_after_data", rd_data, 8'h5A);
    pop();

    // 3: framing error then held-low line
    fe0 = fe_cnt;
    send(8'h41, 1'b0, 1'b0);
    uart_rx = 1'b0;
    repeat (40) @(negedge clock);
    check("t3_ferr_once", fe_cnt - fe0, 1);
    check("t3_count", count, 0);
    idle(20);
    send(8'h42, 1'b1, 1'b0);
    check("t3_ferr_still", fe_cnt - fe0, 1);
    check("t3_count1", count, 1);
    check("t3_data", rd_data, 8'h42);
    pop();

    // 4: overflow by one byte
    ov0 = ov_cnt;
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1, 1'b0);
    check("t4_count", count, DEPTH);
    check("t4_ovr_once", ov_cnt - ov0, 1);
    for (int i = 1; i <= 4; i++) begin
      check("t4_pop_data", rd_data, 32'(i));
      pop();
    end
    check("t4_empty", rd_valid, 0);

    // 5: pop coincides with push into a full FIFO
    for (int b = 1; b <= 4; b++) send(8'(b), 1'b1, 1'b0);
    ov0 = ov_cnt;
    send(8'h06, 1'b1, 1'b1);
    check("t5_ovr", ov_cnt - ov0, 0);
    check("t5_count", count, DEPTH);
    check("t5_head", rd_data, 8'h02);
    pop();
    pop();
    check("t5_count2", count, 2);
    check("t5_head2", rd_data, 8'h04);

    // 6: reset asserted mid-frame during data bit 4
    frame = {1'b1, 8'h7E, 1'b0};
    for (int c = 0; c < 55; c++) begin
      uart_rx = frame[c/10];
      @(negedge clock);
    end
    n_reset = 1'b0;
    #1;
    check("t6_valid", rd_valid, 0);
    check("t6_count", count, 0);
    check("t6_data", rd_data, 8'h00);
    check("t6_ferr", frame_err, 0);
    check("t6_ovr", overrun, 0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clock);
    n_reset = 1'b1;
    idle(20);
    send(8'h33, 1'b1, 1'b0);
    check("t6_count1", count, 1);
    check("t6_data1", rd_data, 8'h33);
    pop();
    check("t6_empty", rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
